pingpong_write_sequencer: RTL and testbench

- Upstream write stage for the dual-bank 64-bit main memory (two 8-entry sub-memories, 2-bit bank write select).
- Accepts a valid/ready stream of 64-bit words and packs them into alternating banks: 8 words per bank, or fewer when closed early by in_last.
- Tracks per-bank full/empty state and stalls the stream until the downstream reader releases a bank.
- Drives the memory's write address, write data and bank-select inputs directly from registers.

---
 rtl/pingpong_write_sequencer.sv | 101 ++++++++++
 tb/tb_pingpong_write_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_write_sequencer.sv
// pingpong_write_sequencer
//   Packs a valid/ready stream of words into two alternating memory banks.
//   Each bank takes up to 2**ADDR_WIDTH words. A bank closes when it is
//   filled or when in_last is seen. A closed bank stays full until the
//   reader pulses its bank_release bit. The memory write port (wr_sel,
//   wr_addr, wr_data) is driven directly from registers, one cycle after
//   the accept.
// Ports:
//   clk, rst          rising-edge clock; synchronous active-high reset
//   in_valid/in_ready stream handshake; in_data word, in_last closes bank
//   bank_release[1:0] one-hot per-bank release pulse from the reader
//                     (this is the reader's "release" input; the name
//                     release is a reserved word in SystemVerilog)
//   wr_addr/wr_data   local address and data to the memory
//   wr_sel[1:0]       01 bank0, 10 bank1, 00 idle
//   bank_full[1:0]    bank holds an unreleased block
//   bank_count0/1     word count of the last closed block per bank
//   release_err       sticky: a release targeted a bank that was not full
module pingpong_write_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [1:0]            bank_release,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [1:0]            wr_sel,
  output logic [1:0]            bank_full,
  output logic [ADDR_WIDTH:0]   bank_count0,
  output logic [ADDR_WIDTH:0]   bank_count1,
  output logic                  release_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;

  logic                  active;
  logic [ADDR_WIDTH-1:0] ptr;

  logic                  accept;
  logic                  closing;
  logic [1:0]            full_nxt;
  logic                  active_nxt;
  logic                  err_nxt;
  logic                  ready_nxt;
  logic [ADDR_WIDTH:0]   cnt_close;

  always_comb begin
    accept    = in_valid && in_ready;
    closing   = accept && ((ptr == LAST_ADDR) || in_last);
    cnt_close = {1'b0, ptr} + CNT_ONE;
    // Releases are judged against the pre-edge full flags, so a release of
    // the bank being closed this very cycle is an error and the close wins.
    full_nxt  = bank_full & ~(bank_release & bank_full);
    err_nxt   = release_err | (|(bank_release & ~bank_full));
    if (closing) full_nxt[active] = 1'b1;
    active_nxt = active ^ closing;
    // in_ready is a registered copy of !bank_full[active], computed from
    // next-state so that a release of the newly active bank in the closing
    // cycle leaves no bubble.
    ready_nxt  = !full_nxt[active_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active      <= 1'b0;
      ptr         <= '0;
      in_ready    <= 1'b0;
      wr_sel      <= 2'b00;
      wr_addr     <= '0;
      wr_data     <= '0;
      bank_full   <= 2'b00;
      bank_count0 <= '0;
      bank_count1 <= '0;
      release_err <= 1'b0;
    end else begin
      bank_full   <= full_nxt;
      release_err <= err_nxt;
      active      <= active_nxt;
      in_ready    <= ready_nxt;
      wr_sel      <= 2'b00;
      if (accept) begin
        wr_sel  <= active ? 2'b10 : 2'b01;
        wr_addr <= ptr;
        wr_data <= in_data;
        ptr     <= closing ? '0 : ptr + PTR_ONE;
      end
      if (closing) begin
        if (active) bank_count1 <= cnt_close;
        else        bank_count0 <= cnt_close;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_write_sequencer.sv
module tb_pingpong_write_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [1:0]  bank_release;
  logic [2:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_sel;
  logic [1:0]  bank_full;
  logic [3:0]  bank_count0;
  logic [3:0]  bank_count1;
  logic        release_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pingpong_write_sequencer #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .bank_release(bank_release),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_sel(wr_sel),
    .bank_full(bank_full), .bank_count0(bank_count0),
    .bank_count1(bank_count1), .release_err(release_err)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted (bounded wait).
  task automatic push(input logic [63:0] d, input logic l);
    logic took;
    took = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int k = 0; k < 20 && !took; k++) begin
      took = in_ready;
      cyc();
    end
    if (!took) chk("push_timeout", 64'd0, 64'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; bank_release = 2'b00;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks the words sitting in the currently filling block as a queue;
  // addresses and counts follow from how many words the block holds.
  logic        m_ready, m_err, m_act;
  logic [1:0]  m_full, m_sel;
  logic [3:0]  m_cnt [2];
  logic [2:0]  m_addr;
  logic [63:0] m_data;
  logic [63:0] blk [$];

  task automatic model_edge(input logic r, input logic v, input logic [63:0] d,
                            input logic l, input logic [1:0] rel);
    logic [1:0] pre;
    if (r) begin
      m_ready = 0; m_err = 0; m_act = 0; m_full = 0; m_sel = 0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_addr = 0; m_data = 0;
      blk.delete();
    end else begin
      pre = m_full;
      for (int b = 0; b < 2; b++)
        if (rel[b]) begin
          if (pre[b]) m_full[b] = 1'b0;
          else        m_err = 1'b1;
        end
      if (v && m_ready) begin
        m_sel  = m_act ? 2'b10 : 2'b01;
        m_addr = 3'(blk.size());
        m_data = d;
        blk.push_back(d);
        if (blk.size() == 8 || l) begin
          m_full[m_act] = 1'b1;
          m_cnt[m_act]  = 4'(blk.size());
          blk.delete();
          m_act = ~m_act;
        end
      end else begin
        m_sel = 2'b00;
      end
      m_ready = !m_full[m_act];
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, valid;
    logic [63:0] data;
    logic        last;
    logic [1:0]  rel;
    logic        ready;
    logic [1:0]  sel;
    logic [2:0]  addr;
    logic [63:0] wdata;
    logic        chk_wd;
    logic [1:0]  full;
    logic [3:0]  cnt0;
    logic        err;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 64'hAA; in_last = 1'b0; bank_release = 2'b00;

    // reset two cycles with in_valid high, then first cycle out of reset
    for (int i = 0; i < 2; i++)
      tbl[i] = '{rst:1, valid:1, data:64'hAA, last:0, rel:0, ready:0, sel:2'b00,
                 addr:0, wdata:0, chk_wd:1, full:2'b00, cnt0:0, err:0};
    tbl[2] = '{rst:0, valid:0, data:0, last:0, rel:0, ready:1, sel:2'b00,
               addr:0, wdata:0, chk_wd:0, full:2'b00, cnt0:0, err:0};
    // fill bank0 with 0..7 at full rate
    for (int i = 0; i < 8; i++)
      tbl[3+i] = '{rst:0, valid:1, data:64'(i), last:0, rel:0, ready:1, sel:2'b01,
                   addr:3'(i), wdata:64'(i), chk_wd:1,
                   full:(i == 7) ? 2'b01 : 2'b00, cnt0:(i == 7) ? 4'd8 : 4'd0, err:0};
    // word 8 goes straight to bank1, then idle
    tbl[11] = '{rst:0, valid:1, data:64'h8, last:0, rel:0, ready:1, sel:2'b10,
                addr:0, wdata:64'h8, chk_wd:1, full:2'b01, cnt0:8, err:0};
    tbl[12] = '{rst:0, valid:0, data:0, last:0, rel:0, ready:1, sel:2'b00,
                addr:0, wdata:0, chk_wd:0, full:2'b01, cnt0:8, err:0};

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].valid; in_data = tbl[i].data;
      in_last = tbl[i].last; bank_release = tbl[i].rel;
      cyc();
      chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].ready));
      chk($sformatf("tbl%0d_sel", i), 64'(wr_sel), 64'(tbl[i].sel));
      chk($sformatf("tbl%0d_full", i), 64'(bank_full), 64'(tbl[i].full));
      chk($sformatf("tbl%0d_cnt0", i), 64'(bank_count0), 64'(tbl[i].cnt0));
      chk($sformatf("tbl%0d_err", i), 64'(release_err), 64'(tbl[i].err));
      if (tbl[i].chk_wd) begin
        chk($sformatf("tbl%0d_addr", i), 64'(wr_addr), 64'(tbl[i].addr));
        chk($sformatf("tbl%0d_data", i), wr_data, tbl[i].wdata);
      end
    end

    // ---------------- stall and release ----------------
    do_reset();
    for (int i = 0; i < 16; i++) push(64'(i), 1'b0);
    chk("stall_last_sel", 64'(wr_sel), 64'(2'b10));
    chk("stall_last_addr", 64'(wr_addr), 64'd7);
    chk("stall_ready", 64'(in_ready), 64'd0);
    chk("stall_full", 64'(bank_full), 64'(2'b11));
    in_valid = 1'b1; in_data = 64'h10;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("stall_hold_sel", 64'(wr_sel), 64'd0);
    end
    bank_release = 2'b01;
    cyc();
    bank_release = 2'b00;
    chk("rel_full", 64'(bank_full), 64'(2'b10));
    chk("rel_ready", 64'(in_ready), 64'd1);
    chk("rel_sel_idle", 64'(wr_sel), 64'd0);
    cyc();
    in_valid = 1'b0;
    chk("rel_write_sel", 64'(wr_sel), 64'(2'b01));
    chk("rel_write_addr", 64'(wr_addr), 64'd0);
    chk("rel_write_data", wr_data, 64'h10);
    chk("rel_err", 64'(release_err), 64'd0);

    // ---------------- early close ----------------
    do_reset();
    push(64'h21, 1'b0);
    push(64'h22, 1'b0);
    push(64'h23, 1'b1);
    chk("early_full", 64'(bank_full), 64'(2'b01));
    chk("early_cnt0", 64'(bank_count0), 64'd3);
    push(64'h24, 1'b0);
    chk("early_next_sel", 64'(wr_sel), 64'(2'b10));
    chk("early_next_addr", 64'(wr_addr), 64'd0);

    // ---------------- release error ----------------
    bank_release = 2'b10;
    cyc();
    bank_release = 2'b00;
    chk("err_set", 64'(release_err), 64'd1);
    chk("err_full", 64'(bank_full), 64'(2'b01));
    chk("err_ready", 64'(in_ready), 64'd1);
    cyc();
    chk("err_sticky", 64'(release_err), 64'd1);

    // ---------------- reset mid-fill ----------------
    for (int i = 0; i < 5; i++) push(64'h30 + 64'(i), 1'b0);
    chk("mid_addr", 64'(wr_addr), 64'd5);
    rst = 1'b1; in_valid = 1'b1; in_data = 64'h55;
    cyc();
    chk("mid_rst_sel", 64'(wr_sel), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_full", 64'(bank_full), 64'd0);
    chk("mid_rst_err", 64'(release_err), 64'd0);
    chk("mid_rst_cnt0", 64'(bank_count0), 64'd0);
    rst = 1'b0;
    cyc();
    chk("mid_after_sel", 64'(wr_sel), 64'd0);
    chk("mid_after_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    chk("mid_write_sel", 64'(wr_sel), 64'(2'b01));
    chk("mid_write_addr", 64'(wr_addr), 64'd0);
    chk("mid_write_data", wr_data, 64'h55);

    // ---------------- randomized against the model ----------------
    for (int i = 0; i < 3000; i++) begin
      logic        r, v, l;
      logic [63:0] d;
      logic [1:0]  rl;
      r  = (i == 0) || ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = {$urandom, $urandom};
      l  = ($urandom_range(0, 5) == 0);
      rl = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rst = r; in_valid = v; in_data = d; in_last = l; bank_release = rl;
      model_edge(r, v, d, l, rl);
      cyc();
      chk("rnd_ready", 64'(in_ready), 64'(m_ready));
      chk("rnd_sel", 64'(wr_sel), 64'(m_sel));
      chk("rnd_full", 64'(bank_full), 64'(m_full));
      chk("rnd_cnt0", 64'(bank_count0), 64'(m_cnt[0]));
      chk("rnd_cnt1", 64'(bank_count1), 64'(m_cnt[1]));
      chk("rnd_err", 64'(release_err), 64'(m_err));
      if (m_sel != 2'b00) begin
        chk("rnd_addr", 64'(wr_addr), 64'(m_addr));
        chk("rnd_data", wr_data, m_data);
      end
    end
    rst = 1'b0; in_valid = 1'b0; bank_release = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
